// File: rtl/vred_unit.sv
// vred_unit: folds up to vl SEW-wide elements of a 128-bit vector into a scalar, one element per clock.
// Optional VRED_UNSIGNED_EN enables unsigned min for red_op=11; otherwise that op returns zero.
module vred_unit #(
    parameter int VLEN = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [VLEN-1:0] vec_in,
    input  logic [VLEN-1:0] scalar_in,
    input  logic [1:0]      red_op,
    input  logic [2:0]      SEW,
    input  logic [7:0]      vl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] red_out,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [VLEN-1:0] vec, acc, mask, e, se, sa, nxt;
    logic [1:0] op;
    logic [2:0] sew;
    logic [7:0] vl_eff, idx, w, cap, in_vl_eff;
    logic lt_s, gt_s, lt_u, seed_zero;

    function automatic logic [VLEN-1:0] mask_of(input logic [2:0] s);
        return s >= 3'd4 ? '1 : (VLEN'(1) << (8 << s)) - VLEN'(1);
    endfunction

    // Sign-extend by testing the element's top bit, found as the highest bit of the mask.
    always_comb begin
        w = 8'd8 << sew;
        mask = mask_of(sew);
        e = vec & mask;
        se = |(e & ~(mask >> 1)) ? e | ~mask : e;
        sa = |(acc & ~(mask >> 1)) ? acc | ~mask : acc;
        lt_s = $signed(se) < $signed(sa);
        gt_s = $signed(se) > $signed(sa);
        nxt = op == 2'd0 ? (acc + e) & mask :
              op == 2'd1 ? (lt_s ? e : acc) :
              op == 2'd2 ? (gt_s ? e : acc) : (lt_u ? e : acc);
        cap = 8'd16 >> SEW;
        in_vl_eff = SEW > 3'd4 ? 8'd0 : (vl < cap ? vl : cap);
    end

`ifdef VRED_UNSIGNED_EN
    assign lt_u = e < acc;
    assign seed_zero = SEW > 3'd4;
`else
    assign lt_u = 1'b0;
    assign seed_zero = SEW > 3'd4 || red_op == 2'd3;
`endif

    assign in_ready = state == IDLE && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vec <= '0;
            acc <= '0;
            op <= '0;
            sew <= '0;
            vl_eff <= '0;
            idx <= '0;
            out_valid <= 1'b0;
            red_out <= '0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    vec <= vec_in;
                    op <= red_op;
                    sew <= SEW;
                    vl_eff <= in_vl_eff;
                    idx <= '0;
                    acc <= seed_zero ? '0 : scalar_in & mask_of(SEW);
                    busy <= 1'b1;
                    state <= in_vl_eff == 8'd0 ? DONE : RUN;
                end
                RUN: begin
                    acc <= nxt;
                    vec <= vec >> w;
                    idx <= idx + 8'd1;
                    if (idx == vl_eff - 8'd1) state <= DONE;
                end
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                    red_out <= acc;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    red_out <= '0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vred_unit.sv
// tb_vred_unit: table vectors, hand-written corner sequences and a random run against a reference model.
module tb_vred_unit;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, busy;
    logic [127:0] vec_in = '0, scalar_in = '0, red_out;
    logic [1:0] red_op = '0;
    logic [2:0] sew = '0;
    logic [7:0] vl = '0;
    int total = 0, bad = 0;

    vred_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .vec_in(vec_in), .scalar_in(scalar_in), .red_op(red_op), .SEW(sew), .vl(vl),
        .out_valid(out_valid), .out_ready(out_ready), .red_out(red_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] vec, seed, exp;
        logic [1:0] op;
        logic [2:0] sew;
        logic [7:0] vl;
        int lat;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: walk elements with plain arithmetic; signed order is compared on left-aligned values.
    function automatic logic [127:0] model(input logic [127:0] v, input logic [127:0] s,
                                           input logic [1:0] o, input logic [2:0] sw,
                                           input logic [7:0] l, output int n);
        int wd, sh;
        logic [127:0] m, a, el;
        n = 0;
        if (sw > 3'd4) return '0;
        wd = 8 << sw;
        sh = 128 - wd;
        n = int'(l) < 128 / wd ? int'(l) : 128 / wd;
        m = wd == 128 ? '1 : (128'd1 << wd) - 128'd1;
        a = s & m;
`ifndef VRED_UNSIGNED_EN
        if (o == 2'd3) return '0;
`endif
        for (int i = 0; i < n; i++) begin
            el = (v >> (i * wd)) & m;
            if (o == 2'd0) a = (a + el) & m;
            else if (o == 2'd1 && $signed(el << sh) < $signed(a << sh)) a = el;
            else if (o == 2'd2 && $signed(el << sh) > $signed(a << sh)) a = el;
            else if (o == 2'd3 && el < a) a = el;
        end
        return a;
    endfunction

    task automatic drive(input logic [127:0] v, input logic [127:0] s, input logic [1:0] o,
                         input logic [2:0] sw, input logic [7:0] l);
        int g = 0;
        vec_in = v; scalar_in = s; red_op = o; sew = sw; vl = l; in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vec_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic collect(input string nm, input logic [127:0] exp, input int lat);
        int cyc;
        wait_out(cyc);
        chk({nm, " result"}, red_out, exp);
        chk({nm, " latency"}, 128'(cyc), 128'(lat));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t tbl[7];
    int n, cyc;
    logic [127:0] exp;

    initial begin
        tbl[0] = '{128'h100F0E0D0C0B0A090807060504030201, 128'h0, 128'h88, 2'd0, 3'd0, 8'd16, 17};
        tbl[1] = '{{32'd100, 32'd7, 32'hFFFFFFFD, 32'd5}, 128'h0, 128'hFFFFFFFD, 2'd1, 3'd2, 8'd4, 5};
        tbl[2] = '{128'h7FFF_7FFF_7FFF_7FFF, 128'hABCD_1234, 128'h1234, 2'd2, 3'd1, 8'd0, 1};
        tbl[3] = '{128'h1234_5678, 128'hFF, 128'h0, 2'd0, 3'd6, 8'd5, 1};
`ifdef VRED_UNSIGNED_EN
        tbl[4] = '{128'h0180, 128'hFF, 128'h01, 2'd3, 3'd0, 8'd2, 3};
`else
        tbl[4] = '{128'h0180, 128'hFF, 128'h00, 2'd3, 3'd0, 8'd2, 3};
`endif
        tbl[5] = '{128'h2, '1, 128'h1, 2'd0, 3'd4, 8'd9, 2};
        tbl[6] = '{{64'h8000_0000_0000_0000, 64'h7}, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 128'h7, 2'd2, 3'd3, 8'd2, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst red_out", red_out, 128'h0);
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].vec, tbl[i].seed, tbl[i].op, tbl[i].sew, tbl[i].vl);
            collect($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].lat);
        end

        // Clamp to two 64-bit elements, then hold the result under back-pressure.
        drive({64'd20, 64'd10}, 128'd5, 2'd0, 3'd3, 8'd20);
        wait_out(cyc);
        chk("clamp result", red_out, 128'd35);
        chk("clamp latency", 128'(cyc), 128'(3));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp red_out", red_out, 128'd35);
            chk("bp out_valid", 128'(out_valid), 128'(1));
            chk("bp in_ready", 128'(in_ready), 128'(0));
        end
        vec_in = {64'd0, 64'd0, 32'd0, 16'd0, 8'd3, 8'd4};
        scalar_in = 128'd0; red_op = 2'd0; sew = 3'd0; vl = 8'd2;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release out_valid", 128'(out_valid), 128'(0));
        chk("release in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next accepted busy", 128'(busy), 128'(1));
        chk("next accepted in_ready", 128'(in_ready), 128'(0));
        collect("next req", 128'd7, 3);

        // Reset lands at the fifth edge after accept, while still folding.
        drive(128'h100F0E0D0C0B0A090807060504030201, 128'h0, 2'd0, 3'd0, 8'd16);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun out_valid", 128'(out_valid), 128'(0));
        chk("midrun busy", 128'(busy), 128'(0));
        chk("midrun red_out", red_out, 128'h0);
        chk("midrun in_ready in rst", 128'(in_ready), 128'(0));
        rst = 1'b0;
        #1;
        chk("midrun in_ready after", 128'(in_ready), 128'(1));
        drive(128'h100F0E0D0C0B0A090807060504030201, 128'h2, 2'd0, 3'd0, 8'd16);
        collect("after rst", 128'h8A, 17);

        for (int i = 0; i < 40; i++) begin
            logic [127:0] v, s;
            logic [1:0] o;
            logic [2:0] sw;
            logic [7:0] l;
            v = {$urandom, $urandom, $urandom, $urandom};
            s = {$urandom, $urandom, $urandom, $urandom};
            o = 2'($urandom_range(0, 3));
            sw = 3'($urandom_range(0, 7));
            l = 8'($urandom_range(0, 20));
            exp = model(v, s, o, sw, l, n);
            drive(v, s, o, sw, l);
            collect($sformatf("rand%0d op%0d sew%0d vl%0d", i, o, sw, l), exp, n + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
